// File: rtl/yin_sample_scheduler_if.sv
// Sample-source, core-link and result-handshake signals of the yin sample scheduler.
// master = surrounding system (source, core, downstream); slave = the scheduler.
interface yin_sample_scheduler_if #(
    parameter int WIDTH = 16,
    parameter int TAU_W = 11
);
    logic [WIDTH-1:0] sample_in;
    logic             sample_valid_in;
    logic [WIDTH-1:0] core_sample_out;
    logic             core_valid_out;
    logic             core_rst_out;
    logic             core_result_valid_in;
    logic [TAU_W-1:0] core_taumin_in;
    logic [TAU_W-1:0] tau_out;
    logic             tau_valid_out;
    logic             tau_ready_in;

    modport master (
        output sample_in, sample_valid_in, core_result_valid_in, core_taumin_in, tau_ready_in,
        input  core_sample_out, core_valid_out, core_rst_out, tau_out, tau_valid_out
    );

    modport slave (
        input  sample_in, sample_valid_in, core_result_valid_in, core_taumin_in, tau_ready_in,
        output core_sample_out, core_valid_out, core_rst_out, tau_out, tau_valid_out
    );
endinterface

// File: rtl/yin_sample_scheduler.sv
// Buffers audio samples, issues them to the yin core at its sample rate, and hands results downstream.
// Optional YIN_ZERO_TAU_SUPPRESS_EN: taumin==0 results are dropped and counted on suppressed_cnt_out.
//
// state   | meaning
// S_IDLE  | waiting for a buffered sample; pops the FIFO head when one is present
// S_ISSUE | one-cycle core_valid_out strobe with the popped sample
// S_GAP   | holds off the next issue so strobes are CYCLES_PER_SAMPLE apart
module yin_sample_scheduler #(
    parameter int WIDTH             = 16,
    parameter int WINDOW_SIZE       = 2048,
    parameter int TAUMAX            = 2048,
    parameter int FIFO_DEPTH        = 8,
    parameter int CYCLES_PER_SAMPLE = 1040
) (
    input  logic                           clk_in,
    input  logic                           rst_n_in,
    input  logic                           flush_in,
    yin_sample_scheduler_if.slave          bus,
    output logic                           overflow_out,
    output logic                           result_lost_out,
`ifdef YIN_ZERO_TAU_SUPPRESS_EN
    output logic [7:0]                     suppressed_cnt_out,
`endif
    output logic [$clog2(WINDOW_SIZE)-1:0] window_idx_out
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int WW = $clog2(WINDOW_SIZE);
    localparam int TW = $clog2(TAUMAX);
    localparam int GW = $clog2(CYCLES_PER_SAMPLE);
    // ISSUE + GAP + IDLE (pop) together span exactly CYCLES_PER_SAMPLE cycles
    localparam logic [GW-1:0] GAP_LOAD = GW'(CYCLES_PER_SAMPLE - 3);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_GAP} state_t;

    state_t           state_q, state_d;
    logic [GW-1:0]    gap_q, gap_d;
    logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0] sample_q, sample_d;
    logic [WW-1:0]    win_idx_q, win_idx_d;
    logic             win_done_q, win_done_d;
    logic [1:0]       pend_q, pend_d;
    logic [TW-1:0]    tau_q, tau_d;
    logic             tau_valid_q, tau_valid_d;
    logic             overflow_q, overflow_d;
    logic             lost_q, lost_d;
    logic             core_rst_q, core_rst_d;
    logic             pop, push, full, empty, issuing, pend_inc, res_take, res_load;
`ifdef YIN_ZERO_TAU_SUPPRESS_EN
    logic [7:0]       supp_q, supp_d;
`endif

    assign full    = (cnt_q == (AW+1)'(FIFO_DEPTH));
    assign empty   = (cnt_q == '0);
    assign issuing = (state_q == S_ISSUE);

    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                gap_d   = GAP_LOAD;
                state_d = S_GAP;
            end
            S_GAP: begin
                if (gap_q == '0) state_d = S_IDLE;
                else             gap_d   = gap_q - GW'(1);
            end
            default: state_d = S_IDLE;
        endcase
        if (flush_in) pop = 1'b0;

        push       = bus.sample_valid_in && (!full || pop) && !flush_in;
        wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        cnt_d      = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
        sample_d   = pop ? mem_q[rd_ptr_q] : sample_q;
        overflow_d = overflow_q | (bus.sample_valid_in && full && !pop);

        win_idx_d  = issuing ? win_idx_q + WW'(1) : win_idx_q;
        win_done_d = win_done_q | (issuing && (&win_idx_q));
        pend_inc   = issuing && (win_idx_q == '0) && win_done_q;
        res_take   = bus.core_result_valid_in && (pend_q != 2'd0);
        pend_d     = pend_q;
        if (pend_inc && !res_take && pend_q != 2'd3) pend_d = pend_q + 2'd1;
        else if (res_take && !pend_inc)              pend_d = pend_q - 2'd1;

`ifdef YIN_ZERO_TAU_SUPPRESS_EN
        res_load = res_take && (bus.core_taumin_in != '0);
        supp_d   = supp_q;
        if (res_take && bus.core_taumin_in == '0 && supp_q != 8'hFF) supp_d = supp_q + 8'd1;
`else
        res_load = res_take;
`endif

        tau_d       = tau_q;
        tau_valid_d = tau_valid_q;
        lost_d      = lost_q;
        if (res_load) begin
            tau_d       = bus.core_taumin_in;
            tau_valid_d = 1'b1;
            if (tau_valid_q && !bus.tau_ready_in) lost_d = 1'b1;
        end else if (tau_valid_q && bus.tau_ready_in) begin
            tau_valid_d = 1'b0;
        end

        core_rst_d = 1'b0;
        if (flush_in) begin
            state_d     = S_IDLE;
            gap_d       = '0;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            cnt_d       = '0;
            overflow_d  = 1'b0;
            win_idx_d   = '0;
            win_done_d  = 1'b0;
            pend_d      = 2'd0;
            tau_valid_d = 1'b0;
            lost_d      = 1'b0;
            core_rst_d  = 1'b1;
`ifdef YIN_ZERO_TAU_SUPPRESS_EN
            supp_d      = 8'd0;
`endif
        end
    end

    always_ff @(posedge clk_in) begin
        if (push) mem_q[wr_ptr_q] <= bus.sample_in;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q     <= S_IDLE;
            gap_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            sample_q    <= '0;
            win_idx_q   <= '0;
            win_done_q  <= 1'b0;
            pend_q      <= 2'd0;
            tau_q       <= '0;
            tau_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            lost_q      <= 1'b0;
            core_rst_q  <= 1'b1;  // holds the core in reset through the first edge after release
`ifdef YIN_ZERO_TAU_SUPPRESS_EN
            supp_q      <= 8'd0;
`endif
        end else begin
            state_q     <= state_d;
            gap_q       <= gap_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            sample_q    <= sample_d;
            win_idx_q   <= win_idx_d;
            win_done_q  <= win_done_d;
            pend_q      <= pend_d;
            tau_q       <= tau_d;
            tau_valid_q <= tau_valid_d;
            overflow_q  <= overflow_d;
            lost_q      <= lost_d;
            core_rst_q  <= core_rst_d;
`ifdef YIN_ZERO_TAU_SUPPRESS_EN
            supp_q      <= supp_d;
`endif
        end
    end

    assign bus.core_sample_out = sample_q;
    assign bus.core_valid_out  = issuing;
    assign bus.core_rst_out    = core_rst_q;
    assign bus.tau_out         = tau_q;
    assign bus.tau_valid_out   = tau_valid_q;
    assign overflow_out        = overflow_q;
    assign result_lost_out     = lost_q;
    assign window_idx_out      = win_idx_q;
`ifdef YIN_ZERO_TAU_SUPPRESS_EN
    assign suppressed_cnt_out  = supp_q;
`endif
endmodule

// File: tb/tb_yin_sample_scheduler.sv
// Directed bench for yin_sample_scheduler (WINDOW_SIZE=8, FIFO_DEPTH=8, CYCLES_PER_SAMPLE=16).
module tb_yin_sample_scheduler;
    localparam int WIDTH = 16, WINDOW_SIZE = 8, TAUMAX = 2048, FIFO_DEPTH = 8, CPS = 16;
    localparam int TW = $clog2(TAUMAX), WW = $clog2(WINDOW_SIZE);

    logic          clk = 1'b0, rst_n = 1'b0, flush = 1'b0;
    logic          overflow, lost;
    logic [WW-1:0] widx;
`ifdef YIN_ZERO_TAU_SUPPRESS_EN
    logic [7:0]    supp;
`endif

    yin_sample_scheduler_if #(.WIDTH(WIDTH), .TAU_W(TW)) bus ();

    yin_sample_scheduler #(
        .WIDTH(WIDTH), .WINDOW_SIZE(WINDOW_SIZE), .TAUMAX(TAUMAX),
        .FIFO_DEPTH(FIFO_DEPTH), .CYCLES_PER_SAMPLE(CPS)
    ) dut (
        .clk_in(clk), .rst_n_in(rst_n), .flush_in(flush), .bus(bus),
        .overflow_out(overflow), .result_lost_out(lost),
`ifdef YIN_ZERO_TAU_SUPPRESS_EN
        .suppressed_cnt_out(supp),
`endif
        .window_idx_out(widx)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int               iss_cyc[$];
    logic [WIDTH-1:0] iss_val[$];
    always @(negedge clk) begin
        if (rst_n && bus.core_valid_out) begin
            iss_cyc.push_back(cyc);
            iss_val.push_back(bus.core_sample_out);
        end
    end

    int total = 0, passed = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [WIDTH-1:0] v);
        bus.sample_in = v;
        bus.sample_valid_in = 1'b1;
        tick(1);
        bus.sample_valid_in = 1'b0;
    endtask

    task automatic result(input logic [TW-1:0] t);
        bus.core_taumin_in = t;
        bus.core_result_valid_in = 1'b1;
        tick(1);
        bus.core_result_valid_in = 1'b0;
    endtask

    task automatic wait_issues(input int n, input int budget);
        int k = 0;
        while (iss_cyc.size() < n && k < budget) begin
            tick(1);
            k++;
        end
    endtask

    initial begin
        int base;
        bus.sample_in = '0;
        bus.sample_valid_in = 1'b0;
        bus.core_result_valid_in = 1'b0;
        bus.core_taumin_in = '0;
        bus.tau_ready_in = 1'b0;

        // reset state
        tick(3);
        chk("rst_core_valid", 32'(bus.core_valid_out), 0);
        chk("rst_core_sample", 32'(bus.core_sample_out), 0);
        chk("rst_tau_valid", 32'(bus.tau_valid_out), 0);
        chk("rst_tau", 32'(bus.tau_out), 0);
        chk("rst_overflow", 32'(overflow), 0);
        chk("rst_lost", 32'(lost), 0);
        chk("rst_widx", 32'(widx), 0);
        chk("rst_core_rst", 32'(bus.core_rst_out), 1);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("core_rst_after_release", 32'(bus.core_rst_out), 1);
        tick(1);
        chk("core_rst_cleared", 32'(bus.core_rst_out), 0);

        // single sample: strobe -> core_valid 2 cycles later
        strobe(16'h1234);
        chk("single_not_yet", 32'(bus.core_valid_out), 0);
        tick(1);
        chk("single_valid", 32'(bus.core_valid_out), 1);
        chk("single_sample", 32'(bus.core_sample_out), 32'h1234);
        tick(1);
        chk("single_valid_drop", 32'(bus.core_valid_out), 0);
        chk("single_widx", 32'(widx), 1);
        chk("single_sample_hold", 32'(bus.core_sample_out), 32'h1234);

        // spurious result before any window completes
        result(11'd5);
        chk("spurious_tau_valid", 32'(bus.tau_valid_out), 0);

        // spacing: 5 consecutive strobes
        tick(20);
        base = iss_cyc.size();
        for (int i = 0; i < 5; i++) begin
            bus.sample_in = WIDTH'(16'hA000 + i);
            bus.sample_valid_in = 1'b1;
            tick(1);
        end
        bus.sample_valid_in = 1'b0;
        wait_issues(base + 5, 200);
        chk("spacing_count", 32'(iss_cyc.size() - base), 5);
        if (iss_cyc.size() >= base + 5) begin
            for (int i = 0; i < 5; i++)
                chk("spacing_order", 32'(iss_val[base+i]), 32'(16'hA000 + i));
            for (int i = 1; i < 5; i++)
                chk("spacing_gap", 32'(iss_cyc[base+i] - iss_cyc[base+i-1]), CPS);
        end
        chk("spacing_no_overflow", 32'(overflow), 0);

        // overflow: 12 back-to-back strobes; 1 popped immediately + 8 buffered = 9 issued
        tick(20);
        base = iss_cyc.size();
        for (int i = 0; i < 12; i++) begin
            bus.sample_in = WIDTH'(16'hB000 + i);
            bus.sample_valid_in = 1'b1;
            tick(1);
        end
        bus.sample_valid_in = 1'b0;
        chk("overflow_set", 32'(overflow), 1);
        wait_issues(base + 9, 400);
        tick(60);
        chk("overflow_issued", 32'(iss_cyc.size() - base), 9);
        if (iss_cyc.size() >= base + 9)
            for (int i = 0; i < 9; i++)
                chk("overflow_order", 32'(iss_val[base+i]), 32'(16'hB000 + i));
        chk("overflow_sticky", 32'(overflow), 1);

        // flush while idle clears sticky flags
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        chk("flush_overflow_clr", 32'(overflow), 0);
        chk("flush_core_rst", 32'(bus.core_rst_out), 1);
        tick(1);
        chk("flush_core_rst_end", 32'(bus.core_rst_out), 0);

        // result handshake: 17 issues -> sample 8 and sample 16 open windows 2 and 3, pending=2
        base = iss_cyc.size();
        for (int i = 0; i < 17; i++) begin
            strobe(WIDTH'(16'hD000 + i));
            wait_issues(base + i + 1, 40);
        end
        chk("hs_issued", 32'(iss_cyc.size() - base), 17);
        chk("hs_widx", 32'(widx), 1);
        result(11'd37);
        chk("hs_valid1", 32'(bus.tau_valid_out), 1);
        chk("hs_tau1", 32'(bus.tau_out), 37);
        chk("hs_lost0", 32'(lost), 0);
        result(11'd52);
        chk("hs_tau2", 32'(bus.tau_out), 52);
        chk("hs_valid2", 32'(bus.tau_valid_out), 1);
        chk("hs_lost1", 32'(lost), 1);
        result(11'd99);
        chk("hs_no_pending", 32'(bus.tau_out), 52);
        bus.tau_ready_in = 1'b1;
        tick(1);
        bus.tau_ready_in = 1'b0;
        chk("hs_accept", 32'(bus.tau_valid_out), 0);

        // flush mid-gap with 3 queued samples and a strobe in the flush cycle
        base = iss_cyc.size();
        strobe(16'hE000);
        wait_issues(base + 1, 10);
        for (int i = 1; i < 4; i++) begin
            bus.sample_in = WIDTH'(16'hE000 + i);
            bus.sample_valid_in = 1'b1;
            tick(1);
        end
        bus.sample_valid_in = 1'b0;
        tick(2);
        flush = 1'b1;
        bus.sample_in = 16'hE0FF;
        bus.sample_valid_in = 1'b1;
        tick(1);
        flush = 1'b0;
        bus.sample_valid_in = 1'b0;
        chk("mflush_core_rst", 32'(bus.core_rst_out), 1);
        chk("mflush_widx", 32'(widx), 0);
        chk("mflush_lost_clr", 32'(lost), 0);
        tick(1);
        chk("mflush_core_rst_end", 32'(bus.core_rst_out), 0);
        base = iss_cyc.size();
        tick(60);
        chk("mflush_no_issue", 32'(iss_cyc.size() - base), 0);
        strobe(16'hC0DE);
        wait_issues(base + 1, 10);
        chk("mflush_new_issue", 32'(iss_cyc.size() - base), 1);
        if (iss_cyc.size() >= base + 1)
            chk("mflush_new_value", 32'(iss_val[base]), 32'hC0DE);

`ifdef YIN_ZERO_TAU_SUPPRESS_EN
        // zero taumin suppressed after one completed window
        tick(20);
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        base = iss_cyc.size();
        for (int i = 0; i < 9; i++) begin
            strobe(WIDTH'(16'hF000 + i));
            wait_issues(base + i + 1, 40);
        end
        result(11'd0);
        chk("supp_tau_valid", 32'(bus.tau_valid_out), 0);
        chk("supp_cnt", 32'(supp), 1);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
